cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Condition/flag stage directly downstream of the ALU in the ARMv4 execute stage.
- Holds the architectural NZCV flag register, loaded from the ALU's z, n, c and v outputs.
- Evaluates the instruction's 4-bit ARM condition field against the stored flags.
- Gates the decoder's write and branch controls with the result, and registers the gated controls into the next pipeline stage.

Parameters:
- FLAG_RST, 4'b0000: reset value of the flag register, bit order {N,Z,C,V}.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  pipeline advance; 0 = stall, all state holds
- flush  input  1  squash the instruction currently in execute
- cond  input  4  ARM condition field, instr[31:28]
- alu_n  input  1  ALU negative flag
- alu_z  input  1  ALU zero flag
- alu_c  input  1  ALU carry flag
- alu_v  input  1  ALU overflow flag
- flag_w  input  2  [1] = update N,Z; [0] = update C,V
- pcs_in  input  1  decoder PC-source/branch request
- reg_w_in  input  1  decoder register-write request
- mem_w_in  input  1  decoder memory-write request
- no_write_in  input  1  compare-class instruction; suppresses the register write
- cond_ex  output  1  combinational condition-passed for the current instruction
- flags  output  4  current flag register {N,Z,C,V}
- pcs_q  output  1  registered, gated branch control
- reg_w_q  output  1  registered, gated register-write control
- mem_w_q  output  1  registered, gated memory-write control

Behaviour:
- Reset: synchronous and active-high, with priority over everything else.
  - flags <= FLAG_RST.
  - pcs_q, reg_w_q and mem_w_q <= 0.
  - cond_ex then reflects FLAG_RST.
- cond_ex is combinational from cond and the stored flags only. It never uses the alu_* inputs, so there is no same-cycle bypass.
- Condition decode:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 1 (treated as always; no exception)
- Flag update, on a rising edge with reset=0, flush=0, en=1 and cond_ex=1:
  - If flag_w[1]: N <= alu_n, Z <= alu_z.
  - If flag_w[0]: C <= alu_c, V <= alu_v.
  - Unselected bits hold.
  - The new flags are visible to cond_ex in the following cycle (1-cycle latency).
- Control pipeline register, on a rising edge with reset=0, flush=0, en=1:
  - pcs_q <= pcs_in & cond_ex.
  - reg_w_q <= reg_w_in & cond_ex & !no_write_in.
  - mem_w_q <= mem_w_in & cond_ex.
- Flush=1 (reset=0), regardless of en:
  - pcs_q, reg_w_q and mem_w_q <= 0.
  - Flags are not updated.
- Stall, en=0 with flush=0: flags and all *_q outputs hold their values.
- Failed condition (cond_ex=0): no flag update and all gated controls are 0, regardless of flag_w and the *_in inputs.
- Back-to-back flag-setting instructions: each one sees only the flags committed by earlier instructions.
- Reset asserted mid-stall or mid-flush: the reset values win on that edge.

Test Plan:
1. Reset with FLAG_RST=0 -> flags=0000, all *_q=0; cond=0 (EQ) gives cond_ex=0, cond=1 (NE) gives cond_ex=1.
2. cond=E, flag_w=11, alu {n,z,c,v}=0100, en=1 -> next cycle flags=0100; cond=0 now gives cond_ex=1.
3. flags=0100, cond=1 (NE), flag_w=11, alu=1011, reg_w_in=1 -> cond_ex=0; flags stay 0100; reg_w_q=0 next cycle.
4. flags=0000, cond=E, flag_w=01, alu=1110 -> flags=0010 (only C,V written); then flag_w=10, alu=1001 -> flags=1010.
5. flags=1000 (N=1, V=0), cond=B (LT), pcs_in=1, mem_w_in=1 -> cond_ex=1, pcs_q=1 and mem_w_q=1 next cycle. Then cond=A (GE) -> cond_ex=0, pcs_q=0.
6. Holding pcs_q=1 with en=0 for 3 cycles -> pcs_q and flags unchanged. Then flush=1 with en=0 -> pcs_q=0 and flags unchanged. Then reset=1 with flush=1 -> flags=FLAG_RST.

Source files
------------

// File: rtl/cond_flag_unit_if.sv
// Bundle of execute-stage signals between the ALU/decoder side and the
// condition/flag unit. The master drives the instruction controls and ALU
// flags; the slave (cond_flag_unit) returns the condition result, the
// committed flags and the registered, gated controls.
interface cond_flag_unit_if;
  logic       en;
  logic       flush;
  logic [3:0] cond;
  logic       alu_n;
  logic       alu_z;
  logic       alu_c;
  logic       alu_v;
  logic [1:0] flag_w;
  logic       pcs_in;
  logic       reg_w_in;
  logic       mem_w_in;
  logic       no_write_in;
  logic       cond_ex;
  logic [3:0] flags;
  logic       pcs_q;
  logic       reg_w_q;
  logic       mem_w_q;

  modport master (
    output en, flush, cond, alu_n, alu_z, alu_c, alu_v, flag_w,
           pcs_in, reg_w_in, mem_w_in, no_write_in,
    input  cond_ex, flags, pcs_q, reg_w_q, mem_w_q
  );

  modport slave (
    input  en, flush, cond, alu_n, alu_z, alu_c, alu_v, flag_w,
           pcs_in, reg_w_in, mem_w_in, no_write_in,
    output cond_ex, flags, pcs_q, reg_w_q, mem_w_q
  );
endinterface

// File: rtl/cond_flag_unit.sv
// ARMv4 execute-stage condition/flag unit. Holds the NZCV register, checks
// the instruction's condition field against the committed flags, and
// registers the decoder's write/branch controls gated by that result.
// cond_ex looks only at the committed flags, so an instruction never sees
// flags produced by its own ALU operation.
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input logic             clk,
  input logic             reset,
  cond_flag_unit_if.slave bus
);

  logic [3:0] flag_q;
  logic       n_f;
  logic       z_f;
  logic       c_f;
  logic       v_f;
  logic       cond_pass;
  logic       pcs_r;
  logic       reg_w_r;
  logic       mem_w_r;

  assign n_f = flag_q[3];
  assign z_f = flag_q[2];
  assign c_f = flag_q[1];
  assign v_f = flag_q[0];

  // Evaluate the condition field against the committed flags only.
  always_comb begin
    cond_pass = 1'b1;
    case (bus.cond)
      4'h0:    cond_pass = z_f;
      4'h1:    cond_pass = !z_f;
      4'h2:    cond_pass = c_f;
      4'h3:    cond_pass = !c_f;
      4'h4:    cond_pass = n_f;
      4'h5:    cond_pass = !n_f;
      4'h6:    cond_pass = v_f;
      4'h7:    cond_pass = !v_f;
      4'h8:    cond_pass = c_f && !z_f;
      4'h9:    cond_pass = !c_f || z_f;
      4'hA:    cond_pass = (n_f == v_f);
      4'hB:    cond_pass = (n_f != v_f);
      4'hC:    cond_pass = !z_f && (n_f == v_f);
      4'hD:    cond_pass = z_f || (n_f != v_f);
      default: cond_pass = 1'b1;
    endcase
  end

  // Commit the selected flag pairs when the instruction advances and passes.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q <= FLAG_RST;
    end else if (!bus.flush && bus.en && cond_pass) begin
      if (bus.flag_w[1]) begin
        flag_q[3] <= bus.alu_n;
        flag_q[2] <= bus.alu_z;
      end
      if (bus.flag_w[0]) begin
        flag_q[1] <= bus.alu_c;
        flag_q[0] <= bus.alu_v;
      end
    end
  end

  // Pipeline register for the gated controls; a flush squashes them even when stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcs_r   <= 1'b0;
      reg_w_r <= 1'b0;
      mem_w_r <= 1'b0;
    end else if (bus.flush) begin
      pcs_r   <= 1'b0;
      reg_w_r <= 1'b0;
      mem_w_r <= 1'b0;
    end else if (bus.en) begin
      pcs_r   <= bus.pcs_in & cond_pass;
      reg_w_r <= bus.reg_w_in & cond_pass & !bus.no_write_in;
      mem_w_r <= bus.mem_w_in & cond_pass;
    end
  end

  assign bus.cond_ex = cond_pass;
  assign bus.flags   = flag_q;
  assign bus.pcs_q   = pcs_r;
  assign bus.reg_w_q = reg_w_r;
  assign bus.mem_w_q = mem_w_r;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: a table of per-cycle vectors, then
// hand-written stall/flush/reset sequences. cond_ex is checked before the
// edge; the expected post-edge state is queued and popped after the edge.
module tb_cond_flag_unit;

  logic clk;
  logic reset;

  cond_flag_unit_if bus_if ();

  cond_flag_unit #(.FLAG_RST(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       flush;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic [3:0] ctl;
    logic       ce;
    logic [3:0] fl;
    logic [2:0] q;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] fl;
    logic [2:0] q;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // alu is {n,z,c,v}; ctl is {pcs,reg_w,mem_w,no_write}; q is {pcs,reg_w,mem_w}.
  function automatic vec_t vec(input logic rst, input logic en, input logic flush,
                               input logic [3:0] cond, input logic [3:0] alu,
                               input logic [1:0] fw, input logic [3:0] ctl,
                               input logic ce, input logic [3:0] fl, input logic [2:0] q);
    vec_t v;
    v.rst = rst; v.en = en; v.flush = flush; v.cond = cond; v.alu = alu;
    v.fw = fw; v.ctl = ctl; v.ce = ce; v.fl = fl; v.q = q;
    return v;
  endfunction

  // Drive one cycle of stimulus, check cond_ex, queue the post-edge expectation.
  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    reset              = v.rst;
    bus_if.en          = v.en;
    bus_if.flush       = v.flush;
    bus_if.cond        = v.cond;
    bus_if.alu_n       = v.alu[3];
    bus_if.alu_z       = v.alu[2];
    bus_if.alu_c       = v.alu[1];
    bus_if.alu_v       = v.alu[0];
    bus_if.flag_w      = v.fw;
    bus_if.pcs_in      = v.ctl[3];
    bus_if.reg_w_in    = v.ctl[2];
    bus_if.mem_w_in    = v.ctl[1];
    bus_if.no_write_in = v.ctl[0];
    #1;
    checks++;
    if (bus_if.cond_ex !== v.ce) begin
      failures++;
      $display("[TB] FAIL %s cond_ex: got %b expected %b", tag, bus_if.cond_ex, v.ce);
    end
    e.tag = tag;
    e.fl  = v.fl;
    e.q   = v.q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput();
    exp_t e;
    logic [2:0] got_q;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    if (bus_if.flags !== e.fl) begin
      failures++;
      $display("[TB] FAIL %s flags: got %b expected %b", e.tag, bus_if.flags, e.fl);
    end
    checks++;
    got_q = {bus_if.pcs_q, bus_if.reg_w_q, bus_if.mem_w_q};
    if (got_q !== e.q) begin
      failures++;
      $display("[TB] FAIL %s pcs/reg_w/mem_w: got %b expected %b", e.tag, got_q, e.q);
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus_if.en          = 1'b1;
    bus_if.flush       = 1'b0;
    bus_if.cond        = 4'hE;
    bus_if.alu_n       = 1'b0;
    bus_if.alu_z       = 1'b0;
    bus_if.alu_c       = 1'b0;
    bus_if.alu_v       = 1'b0;
    bus_if.flag_w      = 2'b00;
    bus_if.pcs_in      = 1'b0;
    bus_if.reg_w_in    = 1'b0;
    bus_if.mem_w_in    = 1'b0;
    bus_if.no_write_in = 1'b0;
    @(posedge clk);
    #1;

    // Reset state and basic EQ/NE.
    tbl.push_back(vec(1, 1, 0, 4'h0, 4'hF, 2'b11, 4'b1110, 0, 4'b0000, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h1, 4'h0, 2'b00, 4'b1110, 1, 4'b0000, 3'b111));
    tbl.push_back(vec(0, 1, 0, 4'h0, 4'hF, 2'b11, 4'b1110, 0, 4'b0000, 3'b000));
    // Full flag write, then EQ passes; no_write suppresses the register write.
    tbl.push_back(vec(0, 1, 0, 4'hE, 4'b0100, 2'b11, 4'b0000, 1, 4'b0100, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h0, 4'b0000, 2'b00, 4'b0101, 1, 4'b0100, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h0, 4'b0000, 2'b00, 4'b0100, 1, 4'b0100, 3'b010));
    // Failed NE blocks both flag update and register write.
    tbl.push_back(vec(0, 1, 0, 4'h1, 4'b1011, 2'b11, 4'b0100, 0, 4'b0100, 3'b000));
    // Partial flag writes.
    tbl.push_back(vec(0, 1, 0, 4'hE, 4'b0000, 2'b11, 4'b0000, 1, 4'b0000, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hE, 4'b1110, 2'b01, 4'b0000, 1, 4'b0010, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hE, 4'b1001, 2'b10, 4'b0000, 1, 4'b1010, 3'b000));
    // Flags N=1 Z=0 C=1 V=0: sweep conditions with pcs and mem requested.
    tbl.push_back(vec(0, 1, 0, 4'h2, 4'h0, 2'b00, 4'b1010, 1, 4'b1010, 3'b101));
    tbl.push_back(vec(0, 1, 0, 4'h3, 4'h0, 2'b00, 4'b1010, 0, 4'b1010, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h4, 4'h0, 2'b00, 4'b1010, 1, 4'b1010, 3'b101));
    tbl.push_back(vec(0, 1, 0, 4'h5, 4'h0, 2'b00, 4'b1010, 0, 4'b1010, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h6, 4'h0, 2'b00, 4'b1010, 0, 4'b1010, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h7, 4'h0, 2'b00, 4'b1010, 1, 4'b1010, 3'b101));
    tbl.push_back(vec(0, 1, 0, 4'h8, 4'h0, 2'b00, 4'b1010, 1, 4'b1010, 3'b101));
    tbl.push_back(vec(0, 1, 0, 4'h9, 4'h0, 2'b00, 4'b1010, 0, 4'b1010, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hA, 4'h0, 2'b00, 4'b1010, 0, 4'b1010, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hB, 4'h0, 2'b00, 4'b1010, 1, 4'b1010, 3'b101));
    tbl.push_back(vec(0, 1, 0, 4'hC, 4'h0, 2'b00, 4'b1010, 0, 4'b1010, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hD, 4'h0, 2'b00, 4'b1010, 1, 4'b1010, 3'b101));
    tbl.push_back(vec(0, 1, 0, 4'hF, 4'h0, 2'b00, 4'b1010, 1, 4'b1010, 3'b101));
    // Flags N=0 Z=1 C=0 V=1: sweep with only reg_w requested.
    tbl.push_back(vec(0, 1, 0, 4'hE, 4'b0101, 2'b11, 4'b0000, 1, 4'b0101, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h0, 4'h0, 2'b00, 4'b0100, 1, 4'b0101, 3'b010));
    tbl.push_back(vec(0, 1, 0, 4'h1, 4'h0, 2'b00, 4'b0100, 0, 4'b0101, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h2, 4'h0, 2'b00, 4'b0100, 0, 4'b0101, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h3, 4'h0, 2'b00, 4'b0100, 1, 4'b0101, 3'b010));
    tbl.push_back(vec(0, 1, 0, 4'h4, 4'h0, 2'b00, 4'b0100, 0, 4'b0101, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h5, 4'h0, 2'b00, 4'b0100, 1, 4'b0101, 3'b010));
    tbl.push_back(vec(0, 1, 0, 4'h6, 4'h0, 2'b00, 4'b0100, 1, 4'b0101, 3'b010));
    tbl.push_back(vec(0, 1, 0, 4'h7, 4'h0, 2'b00, 4'b0100, 0, 4'b0101, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h8, 4'h0, 2'b00, 4'b0100, 0, 4'b0101, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'h9, 4'h0, 2'b00, 4'b0100, 1, 4'b0101, 3'b010));
    tbl.push_back(vec(0, 1, 0, 4'hA, 4'h0, 2'b00, 4'b0100, 0, 4'b0101, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hB, 4'h0, 2'b00, 4'b0100, 1, 4'b0101, 3'b010));
    tbl.push_back(vec(0, 1, 0, 4'hC, 4'h0, 2'b00, 4'b0100, 0, 4'b0101, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hD, 4'h0, 2'b00, 4'b0100, 1, 4'b0101, 3'b010));
    // All-clear flags: GT, GE pass; HI fails.
    tbl.push_back(vec(0, 1, 0, 4'hE, 4'b0000, 2'b11, 4'b0000, 1, 4'b0000, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hC, 4'h0, 2'b00, 4'b1000, 1, 4'b0000, 3'b100));
    tbl.push_back(vec(0, 1, 0, 4'hA, 4'h0, 2'b00, 4'b1000, 1, 4'b0000, 3'b100));
    tbl.push_back(vec(0, 1, 0, 4'h8, 4'h0, 2'b00, 4'b1000, 0, 4'b0000, 3'b000));
    // N=1 V=0: LT branch and store pass, GE fails.
    tbl.push_back(vec(0, 1, 0, 4'hE, 4'b1000, 2'b10, 4'b0000, 1, 4'b1000, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hB, 4'h0, 2'b00, 4'b1010, 1, 4'b1000, 3'b101));
    tbl.push_back(vec(0, 1, 0, 4'hA, 4'h0, 2'b00, 4'b1010, 0, 4'b1000, 3'b000));
    tbl.push_back(vec(0, 1, 0, 4'hE, 4'h0, 2'b00, 4'b1000, 1, 4'b1000, 3'b100));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // Stall three cycles with pcs_q=1 and a pending flag write: everything holds.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vec(0, 0, 0, 4'hE, 4'b0111, 2'b11, 4'b0000, 1, 4'b1000, 3'b100),
                    $sformatf("stall%0d", i));
    end
    // Flush while stalled clears controls, keeps flags.
    applyStimulus(vec(0, 0, 1, 4'hE, 4'b0111, 2'b11, 4'b0000, 1, 4'b1000, 3'b000), "flush_stall");
    // Reset together with flush restores FLAG_RST.
    applyStimulus(vec(1, 0, 1, 4'hE, 4'b0111, 2'b11, 4'b1110, 1, 4'b0000, 3'b000), "rst_flush");
    applyStimulus(vec(0, 1, 0, 4'h0, 4'b0000, 2'b00, 4'b0000, 0, 4'b0000, 3'b000), "post_rst_eq");
    // Flush with en=1 blocks the flag write and the controls.
    applyStimulus(vec(0, 1, 0, 4'hE, 4'b1111, 2'b11, 4'b1110, 1, 4'b1111, 3'b111), "set_all");
    applyStimulus(vec(0, 1, 1, 4'hE, 4'b0000, 2'b11, 4'b1110, 1, 4'b1111, 3'b000), "flush_en");
    // Reset asserted during a stall still wins.
    applyStimulus(vec(0, 1, 0, 4'hE, 4'b0000, 2'b00, 4'b1010, 1, 4'b1111, 3'b101), "set_q");
    applyStimulus(vec(1, 0, 0, 4'hE, 4'b0000, 2'b11, 4'b1110, 1, 4'b0000, 3'b000), "rst_stall");

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
